// File: rtl/ifft_4point.sv
// ifft_4point: four-point inverse DFT over a streamed frame.
// Loads X[0..3], computes in one cycle, then streams x[0..3].
module ifft_4point (
    input  logic       clk,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_re,
    input  logic [7:0] in_im,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] y_re,
    output logic [7:0] y_im,
    output logic [1:0] out_idx
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0] cnt;
    logic [7:0] xr [4];
    logic [7:0] xi [4];
    logic [7:0] br [4];
    logic [7:0] bi [4];

    logic signed [9:0] r [4];
    logic signed [9:0] i [4];
    logic signed [9:0] sr [4];
    logic signed [9:0] si [4];

    logic       accept;
    logic       last_out;
    logic [1:0] nidx;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid & in_ready;
    assign last_out = out_valid && (out_idx == 2'd3);
    assign nidx     = out_idx + 2'd1;

    // State register; clear always returns to LOAD.
    always_ff @(posedge clk) begin
        if (clear) state <= LOAD;
        else       state <= state_nx;
    end

    // Next-state: 4 accepts, one compute cycle, then drain the buffer.
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (accept && cnt == 2'd3) state_nx = CALC;
            CALC:    state_nx = OUT;
            OUT:     if (last_out) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Butterfly sums on 10-bit sign-extended samples (|S| <= 512).
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            r[k] = {{2{xr[k][7]}}, xr[k]};
            i[k] = {{2{xi[k][7]}}, xi[k]};
        end
        sr[0] = r[0] + r[1] + r[2] + r[3];
        si[0] = i[0] + i[1] + i[2] + i[3];
        sr[1] = r[0] - i[1] - r[2] + i[3];
        si[1] = i[0] + r[1] - i[2] - r[3];
        sr[2] = r[0] - r[1] + r[2] - r[3];
        si[2] = i[0] - i[1] + i[2] - i[3];
        sr[3] = r[0] + i[1] - r[2] - i[3];
        si[3] = i[0] - r[1] - i[2] + r[3];
    end

    // Sample capture, compute into buffer, registered output stream.
    // The first OUT cycle is a bubble so x[0] appears two edges after X[3].
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            y_re      <= 8'd0;
            y_im      <= 8'd0;
            out_idx   <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                xr[k] <= 8'd0;
                xi[k] <= 8'd0;
                br[k] <= 8'd0;
                bi[k] <= 8'd0;
            end
        end else begin
            if (accept) begin
                xr[cnt] <= in_re;
                xi[cnt] <= in_im;
                cnt     <= cnt + 2'd1;
            end
            if (state == CALC) begin
                for (int k = 0; k < 4; k++) begin
                    br[k] <= sr[k][9:2];
                    bi[k] <= si[k][9:2];
                end
            end
            if (state == OUT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_idx   <= 2'd0;
                    y_re      <= br[0];
                    y_im      <= bi[0];
                end else if (out_idx == 2'd3) begin
                    out_valid <= 1'b0;
                    out_idx   <= 2'd0;
                    y_re      <= 8'd0;
                    y_im      <= 8'd0;
                end else begin
                    out_idx <= nidx;
                    y_re    <= br[nidx];
                    y_im    <= bi[nidx];
                end
            end
        end
    end

endmodule
